// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL bring-up and lock supervisor.
// Holds the PLL in reset, waits for a filtered lock and then releases the
// downstream reset. Attempts that time out are retried a bounded number of
// times before the block parks in FAIL until relock_req.
// Optional feature macro: PLL_LOSS_RELOCK_EN -- when defined, losing lock in
// READY restarts the whole bring-up; when undefined, READY is terminal.
module pll_lock_ctrl #(
  parameter int RST_HOLD_CYC     = 270,
  parameter int LOCK_STABLE_CYC  = 2700,
  parameter int LOCK_TIMEOUT_CYC = 270000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [3:0] retry_cnt
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYC + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_FAIL
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [STAB_W-1:0]   stable_q, stable_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [3:0]          retry_q, retry_d;
  logic                sync1_q, lock_sync_q;
  logic                pll_reset_q, rst_out_n_q, pll_ready_q, pll_fail_q;
  logic                qualified, timeout;

  // Two-flop synchronizer: every decision below uses lock_sync_q only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      sync1_q     <= pll_lock;
      lock_sync_q <= sync1_q;
    end
  end

  // Lock held long enough this cycle; beats a simultaneous timeout.
  assign qualified = (state_q == ST_STABLE) && lock_sync_q && (stable_q == STAB_LAST);
  assign timeout   = (tmo_q == TMO_LAST);

  // Next-state and counter logic; relock_req overrides everything.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    if (relock_req) begin
      state_d  = ST_RESET;
      hold_d   = '0;
      stable_d = '0;
      tmo_d    = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (hold_q == HOLD_LAST) begin
            state_d  = ST_WAIT_LOCK;
            hold_d   = '0;
            stable_d = '0;
            tmo_d    = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          if (qualified) begin
            state_d  = ST_READY;
            retry_d  = '0;
            stable_d = '0;
            tmo_d    = '0;
          end else if (timeout) begin
            stable_d = '0;
            tmo_d    = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_RESET;
              hold_d  = '0;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            // Timeout keeps running across STABLE/WAIT_LOCK bounces.
            tmo_d = tmo_q + 1'b1;
            if (!lock_sync_q) begin
              state_d  = ST_WAIT_LOCK;
              stable_d = '0;
            end else if (state_q == ST_WAIT_LOCK) begin
              state_d  = ST_STABLE;
              stable_d = '0;
            end else begin
              stable_d = stable_q + 1'b1;
            end
          end
        end
        ST_READY: begin
`ifdef PLL_LOSS_RELOCK_EN
          if (!lock_sync_q) begin
            state_d  = ST_RESET;
            hold_d   = '0;
            stable_d = '0;
            tmo_d    = '0;
            retry_d  = '0;
          end
`else
          // Lock loss is ignored; only relock_req or sys_rst_n leave READY.
          state_d = ST_READY;
`endif
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          hold_d  = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RESET;
      hold_q      <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_out_n_q <= 1'b0;
      pll_ready_q <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      rst_out_n_q <= (state_d == ST_READY);
      pll_ready_q <= (state_d == ST_READY);
      pll_fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign rst_out_n = rst_out_n_q;
  assign pll_ready = pll_ready_q;
  assign pll_fail  = pll_fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl: table of bring-up scenarios, hand-written
// corner sequences and a randomized run, all checked against a phase/run-length
// reference model. Honours PLL_LOSS_RELOCK_EN the same way as the design.
module tb_pll_lock_ctrl;

  localparam int H  = 4;
  localparam int L  = 8;
  localparam int T  = 32;
  localparam int MR = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, rst_out_n, pll_ready, pll_fail;
  logic [3:0] retry_cnt;

  pll_lock_ctrl #(
    .RST_HOLD_CYC     (H),
    .LOCK_STABLE_CYC  (L),
    .LOCK_TIMEOUT_CYC (T),
    .MAX_RETRY        (MR)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .rst_out_n  (rst_out_n),
    .pll_ready  (pll_ready),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, age within phase, run of consecutive lock samples.
  localparam int P_HOLD = 0, P_SEARCH = 1, P_UP = 2, P_DEAD = 3;
  int         m_phase, m_age, m_run, m_retries;
  logic [1:0] m_sync;

  function automatic void model_reset();
    m_phase   = P_HOLD;
    m_age     = 0;
    m_run     = 0;
    m_retries = 0;
    m_sync    = 2'b00;
  endfunction

  function automatic void model_edge();
    logic seen;
    seen   = m_sync[1];
    m_sync = {m_sync[0], pll_lock};
    if (relock_req) begin
      m_phase = P_HOLD; m_age = 0; m_run = 0; m_retries = 0;
    end else if (m_phase == P_HOLD) begin
      m_age++;
      if (m_age == H) begin
        m_phase = P_SEARCH; m_age = 0; m_run = 0;
      end
    end else if (m_phase == P_SEARCH) begin
      m_age++;
      m_run = seen ? m_run + 1 : 0;
      if (m_run == L + 1) begin
        m_phase = P_UP; m_retries = 0;
      end else if (m_age == T) begin
        if (m_retries < MR) begin
          m_retries++; m_phase = P_HOLD; m_age = 0; m_run = 0;
        end else begin
          m_phase = P_DEAD;
        end
      end
    end else if (m_phase == P_UP) begin
`ifdef PLL_LOSS_RELOCK_EN
      if (!seen) begin
        m_phase = P_HOLD; m_age = 0; m_run = 0; m_retries = 0;
      end
`endif
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pll_reset", int'(pll_reset), int'(m_phase == P_HOLD || m_phase == P_DEAD));
    chk("rst_out_n", int'(rst_out_n), int'(m_phase == P_UP));
    chk("pll_ready", int'(pll_ready), int'(m_phase == P_UP));
    chk("pll_fail",  int'(pll_fail),  int'(m_phase == P_DEAD));
    chk("retry_cnt", int'(retry_cnt), m_retries);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pll_reset"}, int'(pll_reset), 1);
    chk({tag, "_rst_out_n"}, int'(rst_out_n), 0);
    chk({tag, "_pll_ready"}, int'(pll_ready), 0);
    chk({tag, "_pll_fail"},  int'(pll_fail),  0);
    chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
  endtask

  // One clock edge: advance the model, compare shortly after the edge.
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_model();
    #1;
  endtask

  // Async reset asserted between edges, held across one edge, released mid-cycle.
  task automatic do_reset();
    sys_rst_n  = 1'b0;
    relock_req = 1'b0;
    #1;
    model_reset();
    check_reset("async_rst");
    @(posedge sys_clk);
    #1;
    check_reset("rst_held");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    int rise;       // first edge at which pll_lock is sampled high
    int gap;        // edge at which pll_lock is sampled low once (0 = none)
    int exp_ready;  // edge after which pll_ready is first high
    int exp_retry;  // largest retry_cnt seen before READY
    int exp_rst;    // cycles with pll_reset high before READY
  } vec_t;

  vec_t vecs [6];

  int ready_e, max_retry, rst_hi, fail_e, pulses;
  int run_left;
  logic prev_rst;

  initial begin
    vecs[0] = '{1,  0,  13, 0, 4};   // lock present from the start
    vecs[1] = '{11, 0,  21, 0, 4};   // clean bring-up, N+10
    vecs[2] = '{6,  11, 22, 0, 4};   // 5 high, 1 low, then high
    vecs[3] = '{5,  13, 24, 0, 4};   // drop on the last stable cycle
    vecs[4] = '{26, 0,  36, 0, 4};   // qualifies on the timeout edge
    vecs[5] = '{27, 0,  49, 1, 8};   // one cycle too late: one retry

    #2;
    do_reset();

    // Table-driven bring-up scenarios.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ready_e = 0; max_retry = 0; rst_hi = 1;
      for (int e = 1; e <= 80; e++) begin
        pll_lock = (e >= vecs[v].rise) && (e != vecs[v].gap);
        step();
        if (ready_e == 0) begin
          if (pll_reset) rst_hi++;
          if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
          if (pll_ready) ready_e = e;
        end
        if (ready_e != 0 && e >= ready_e + 2) break;
      end
      chk($sformatf("vec%0d_ready_edge", v), ready_e, vecs[v].exp_ready);
      chk($sformatf("vec%0d_max_retry", v), max_retry, vecs[v].exp_retry);
      chk($sformatf("vec%0d_reset_cycles", v), rst_hi, vecs[v].exp_rst);
      chk($sformatf("vec%0d_rst_out_n", v), int'(rst_out_n), 1);
      $display("vec%0d: rise=%0d gap=%0d ready_edge=%0d", v, vecs[v].rise, vecs[v].gap, ready_e);
    end

    // Never locks: three 4-cycle reset pulses, then FAIL held indefinitely.
    do_reset();
    pll_lock = 1'b0;
    fail_e = 0; pulses = 1; rst_hi = 1; prev_rst = 1'b1;
    for (int e = 1; e <= 140; e++) begin
      step();
      if (fail_e == 0) begin
        if (pll_fail) begin
          fail_e = e;
        end else begin
          if (pll_reset) begin
            rst_hi++;
            if (!prev_rst) pulses++;
          end
          prev_rst = pll_reset;
        end
      end
      if (e == 36) chk("retry_after_timeout1", int'(retry_cnt), 1);
      if (e == 72) chk("retry_after_timeout2", int'(retry_cnt), 2);
    end
    chk("nolock_fail_edge", fail_e, 108);
    chk("nolock_reset_pulses", pulses, 3);
    chk("nolock_reset_cycles", rst_hi, 12);
    chk("fail_held_pll_fail", int'(pll_fail), 1);
    chk("fail_held_pll_reset", int'(pll_reset), 1);
    chk("fail_held_rst_out_n", int'(rst_out_n), 0);
    chk("fail_held_retry", int'(retry_cnt), 2);
    $display("nolock: fail_edge=%0d pulses=%0d reset_cycles=%0d", fail_e, pulses, rst_hi);

    // Recovery from FAIL via relock_req with lock now present.
    relock_req = 1'b1;
    pll_lock   = 1'b1;
    step();
    relock_req = 1'b0;
    chk("relock_pll_reset", int'(pll_reset), 1);
    chk("relock_pll_fail", int'(pll_fail), 0);
    chk("relock_retry", int'(retry_cnt), 0);
    ready_e = 0; rst_hi = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ready_e == 0) begin
        if (pll_reset) rst_hi++;
        if (pll_ready) ready_e = k;
      end
    end
    chk("relock_ready_offset", ready_e, 13);
    chk("relock_reset_cycles", rst_hi, 4);
    $display("relock: ready_offset=%0d reset_cycles=%0d", ready_e, rst_hi);

    // Lock loss in READY: pll_lock low for 3 sampled cycles.
    for (int k = 1; k <= 12; k++) begin
      pll_lock = (k > 3);
      step();
`ifdef PLL_LOSS_RELOCK_EN
      if (k == 2) chk("loss_rst_out_n_before", int'(rst_out_n), 1);
      if (k == 3) begin
        chk("loss_rst_out_n_after", int'(rst_out_n), 0);
        chk("loss_pll_reset_after", int'(pll_reset), 1);
      end
`else
      chk("loss_pll_ready_kept", int'(pll_ready), 1);
      chk("loss_rst_out_n_kept", int'(rst_out_n), 1);
`endif
    end
    $display("lock_loss: pll_ready=%0b rst_out_n=%0b", pll_ready, rst_out_n);

    // Async reset mid-STABLE, then a full restart.
    do_reset();
    pll_lock = 1'b1;
    repeat (8) step();
    chk("mid_stable_ready", int'(pll_ready), 0);
    chk("mid_stable_pll_reset", int'(pll_reset), 0);
    do_reset();
    ready_e = 0; rst_hi = 1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (ready_e == 0) begin
        if (pll_reset) rst_hi++;
        if (pll_ready) ready_e = e;
      end
    end
    chk("restart_ready_edge", ready_e, 13);
    chk("restart_reset_cycles", rst_hi, 4);
    $display("async_restart: ready_edge=%0d reset_cycles=%0d", ready_e, rst_hi);

    // Randomized lock runs, relock requests and occasional async resets.
    do_reset();
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      if (run_left == 0) begin
        pll_lock = ($urandom_range(0, 99) < 65);
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                               : int'($urandom_range(1, 6));
      end
      run_left--;
      relock_req = ($urandom_range(0, 149) == 0);
      step();
    end
    relock_req = 1'b0;
    $display("random: 3000 cycles done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
